// File: rtl/uart_pkg.sv
// Shared UART constants and baud-generator state encoding.
// Used by the RX and TX baud generators.
package uart_pkg;

    // Default divisor widths shared by both baud generators
    localparam int unsigned UART_DIV_W  = 16;
    localparam int unsigned UART_FRAC_W = 4;

    // Divisors below this value are clamped up to it
    localparam int unsigned BPS_DIV_MIN = 2;

    // Baud generator state encoding
    typedef logic [1:0] bps_state_t;
    localparam bps_state_t BPS_IDLE = 2'd0;
    localparam bps_state_t BPS_HALF = 2'd1;
    localparam bps_state_t BPS_FULL = 2'd2;

endpackage : uart_pkg

// File: rtl/uart_bps_frac_acc.sv
// Fractional baud accumulator: adds the fraction at each full-period terminal
// count and holds the carry-out so it can stretch the following period.
module uart_bps_frac_acc #(
    parameter int unsigned FRAC_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              step_i,
    input  logic [FRAC_W-1:0] frac_i,
    output logic              carry_o
);

    logic [FRAC_W-1:0] acc_q;
    logic              carry_q;
    logic [FRAC_W:0]   sum_c;

    // Modulo-2^FRAC_W add with carry-out
    assign sum_c   = {1'b0, acc_q} + {1'b0, frac_i};
    assign carry_o = carry_q;

    // Accumulator register: cleared whenever the generator is idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            carry_q <= 1'b0;
        end else if (clr_i) begin
            acc_q   <= '0;
            carry_q <= 1'b0;
        end else if (step_i) begin
            acc_q   <= sum_c[FRAC_W-1:0];
            carry_q <= sum_c[FRAC_W];
        end
    end

endmodule : uart_bps_frac_acc

// File: rtl/uart_rx_bps.sv
// Receive baud-tick generator. First pulse lands mid start bit (div/2 cycles
// after the enable capture), later pulses every div cycles.
// Optional fractional divisor: define UART_RX_BPS_FRAC_EN.
module uart_rx_bps
    import uart_pkg::*;
#(
    parameter int unsigned DIV_W  = UART_DIV_W,
    parameter int unsigned FRAC_W = UART_FRAC_W
) (
    input  logic              clk26m,
    input  logic              rst26m_,
    input  logic              rx_bpsen,
    input  logic [DIV_W-1:0]  bps_div,
    input  logic [FRAC_W-1:0] bps_frac,
    output logic              rx_bpsclk,
    output logic              bps_active
);

    // One extra bit so a stretched period of 2^DIV_W does not wrap
    localparam int unsigned CNT_W = DIV_W + 1;

    bps_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [DIV_W-1:0]  div_q,   div_d;
    logic              pulse_q, pulse_d;
    logic              active_q, active_d;
    logic              carry_c;
    logic [CNT_W-1:0]  half_last_c;
    logic [CNT_W-1:0]  full_last_c;

    assign rx_bpsclk  = pulse_q;
    assign bps_active = active_q;

    // Terminal counts for the half and full bit periods
    assign half_last_c = CNT_W'(div_q >> 1) - CNT_W'(1);
    assign full_last_c = CNT_W'(div_q) + CNT_W'(carry_c) - CNT_W'(1);

`ifdef UART_RX_BPS_FRAC_EN
    logic [FRAC_W-1:0] frac_q;
    logic              acc_clr_c;
    logic              acc_step_c;

    // Fraction is captured alongside the integer divisor
    always_ff @(posedge clk26m or negedge rst26m_) begin
        if (!rst26m_) begin
            frac_q <= '0;
        end else if (state_q == BPS_IDLE && rx_bpsen) begin
            frac_q <= bps_frac;
        end
    end

    assign acc_clr_c  = (state_q == BPS_IDLE) || !rx_bpsen;
    assign acc_step_c = (state_q == BPS_FULL) && rx_bpsen && (cnt_q == full_last_c);

    uart_bps_frac_acc #(
        .FRAC_W (FRAC_W)
    ) u_frac_acc (
        .clk     (clk26m),
        .rst_n   (rst26m_),
        .clr_i   (acc_clr_c),
        .step_i  (acc_step_c),
        .frac_i  (frac_q),
        .carry_o (carry_c)
    );
`else
    logic unused_frac_c;

    // Fraction port kept for interface stability only
    assign unused_frac_c = ^bps_frac;
    assign carry_c       = 1'b0;
`endif

    // State, counter, divisor and output registers
    always_ff @(posedge clk26m or negedge rst26m_) begin
        if (!rst26m_) begin
            state_q  <= BPS_IDLE;
            cnt_q    <= '0;
            div_q    <= DIV_W'(BPS_DIV_MIN);
            pulse_q  <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            pulse_q  <= pulse_d;
            active_q <= active_d;
        end
    end

    // Next-state, counter and pulse decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        pulse_d = 1'b0;

        case (state_q)
            BPS_IDLE: begin
                cnt_d = '0;
                if (rx_bpsen) begin
                    div_d   = (bps_div < DIV_W'(BPS_DIV_MIN)) ? DIV_W'(BPS_DIV_MIN) : bps_div;
                    state_d = BPS_HALF;
                end
            end
            BPS_HALF: begin
                if (!rx_bpsen) begin
                    cnt_d   = '0;
                    state_d = BPS_IDLE;
                end else if (cnt_q == half_last_c) begin
                    pulse_d = 1'b1;
                    cnt_d   = '0;
                    state_d = BPS_FULL;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            BPS_FULL: begin
                if (!rx_bpsen) begin
                    cnt_d   = '0;
                    state_d = BPS_IDLE;
                end else if (cnt_q == full_last_c) begin
                    pulse_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = BPS_IDLE;
            end
        endcase

        active_d = (state_d != BPS_IDLE);
    end

endmodule : uart_rx_bps
